// File: rtl/mtm_alu_deserializer_p.sv
// rtl/mtm_alu_deserializer_p.sv - serial ALU command deserializer with framing, length and CRC checks
//
// Decodes 11-bit packets (start=0, type, 8 payload bits MSB first, stop=1)
// from a one-bit-per-cycle serial line. A transaction is 2*NBYTES DATA
// packets (operand A then operand B, most significant byte first) closed
// by one CTL packet carrying {1'b0, op[2:0], crc[3:0]}.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   sin        serial line, idles high
//   out_a      operand A of the last successful transaction
//   out_b      operand B of the last successful transaction
//   out_op     operation code of the last successful transaction
//   out_valid  one-cycle pulse: transaction finished or framing error seen
//   out_err    {err_data, err_crc, err_frame}, zero when out_valid is low

module mtm_alu_deserializer_p #(
    parameter  int WIDTH  = 32,
    localparam int NBYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_op,
    output logic             out_valid,
    output logic [2:0]       out_err
);

    localparam int NDATA = 2 * NBYTES;
    localparam int CW    = $clog2(NDATA + 2);
    localparam logic [CW-1:0] NDATA_C = CW'(NDATA);
    localparam logic [CW-1:0] SAT_C   = CW'(NDATA + 1);

    typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, RESYNC} state_t;

    state_t             state_q;
    logic               type_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         payload_q;
    logic [CW-1:0]      data_cnt_q;
    logic [2*WIDTH-1:0] shreg_q;
    logic [3:0]         crc_q;
    logic [WIDTH-1:0]   out_a_q;
    logic [WIDTH-1:0]   out_b_q;
    logic [2:0]         out_op_q;
    logic               out_valid_q;
    logic [2:0]         out_err_q;

    // The CRC runs over {A, B, 1'b1, op} while the bits arrive. DATA payload
    // bits feed it directly (surplus bytes excluded). In the CTL payload the
    // leading 0 slot is replaced by the constant 1, then the three op bits
    // follow; the trailing four crc bits are not fed.
    logic       crc_en;
    logic       crc_bit;
    logic       crc_fb;
    logic [3:0] crc_d;

    always_comb begin
        crc_en  = 1'b0;
        crc_bit = sin;
        if (state_q == PAYLOAD) begin
            if (!type_q) begin
                crc_en = (data_cnt_q < NDATA_C);
            end else if (bit_cnt_q <= 3'd3) begin
                crc_en = 1'b1;
                if (bit_cnt_q == 3'd0) begin
                    crc_bit = 1'b1;
                end
            end
        end
        crc_fb = crc_q[3] ^ crc_bit;
        crc_d  = {crc_q[2], crc_q[1], crc_q[0] ^ crc_fb, crc_fb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            type_q      <= 1'b0;
            bit_cnt_q   <= 3'd0;
            payload_q   <= 8'd0;
            data_cnt_q  <= '0;
            shreg_q     <= '0;
            crc_q       <= 4'd0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= 3'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= 3'd0;
        end else begin
            out_valid_q <= 1'b0;
            out_err_q   <= 3'd0;
            if (crc_en) begin
                crc_q <= crc_d;
            end
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_q <= TYPE;
                    end
                end
                TYPE: begin
                    type_q  <= sin;
                    state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    payload_q <= {payload_q[6:0], sin};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (sin) begin
                        state_q <= IDLE;
                        if (!type_q) begin
                            if (data_cnt_q < NDATA_C) begin
                                shreg_q <= {shreg_q[2*WIDTH-9:0], payload_q};
                            end
                            if (data_cnt_q != SAT_C) begin
                                data_cnt_q <= data_cnt_q + CW'(1);
                            end
                        end else begin
                            out_valid_q <= 1'b1;
                            if (data_cnt_q != NDATA_C) begin
                                out_err_q <= 3'b100;
                            end else if (crc_q != payload_q[3:0]) begin
                                out_err_q <= 3'b010;
                            end else begin
                                out_a_q  <= shreg_q[2*WIDTH-1:WIDTH];
                                out_b_q  <= shreg_q[WIDTH-1:0];
                                out_op_q <= payload_q[6:4];
                            end
                            data_cnt_q <= '0;
                            shreg_q    <= '0;
                            crc_q      <= 4'd0;
                        end
                    end else begin
                        state_q     <= RESYNC;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 3'b001;
                        data_cnt_q  <= '0;
                        shreg_q     <= '0;
                        crc_q       <= 4'd0;
                    end
                end
                RESYNC: begin
                    if (sin) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_op    = out_op_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer_p.sv
// tb/tb_mtm_alu_deserializer_p.sv - directed self-checking bench for mtm_alu_deserializer_p

module tb_mtm_alu_deserializer_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        out_valid;
    logic [2:0]  out_err;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int qual_viol = 0;

    mtm_alu_deserializer_p #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_valid (out_valid),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) vcnt++;
        if (out_valid !== 1'b1 && out_err !== 3'b000) qual_viol++;
    end

    function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [67:0] v;
        logic [3:0]  c;
        logic        fb;
        v = {a, b, 1'b1, op};
        c = 4'd0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] d);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(1'b1);
    endtask

    task automatic send_data(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, b[8*i +: 8]);
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", out_err); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL reset_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL reset_b got %h want 0", out_b); end
        checks++; if (out_op !== 3'b000) begin errors++; $display("FAIL reset_op got %b want 000", out_op); end
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic test_zero_txn();
        int v0;
        v0 = vcnt;
        send_data(32'h0, 32'h0);
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL zero_nopulse got %0d want %0d", vcnt, v0); end
        send_pkt(1'b1, 8'h0B);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL zero_err got %b want 000", out_err); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL zero_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL zero_b got %h want 0", out_b); end
        checks++; if (out_op !== 3'b000) begin errors++; $display("FAIL zero_op got %b want 000", out_op); end
        send_bit(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse_len got %b want 0", out_valid); end
        checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL zero_pulse_cnt got %0d want %0d", vcnt, v0 + 1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ctl;
        ctl = {1'b0, 3'b101, crc_ref(32'h01020304, 32'hA0B0C0D0, 3'b101)};
        send_data(32'h01020304, 32'hA0B0C0D0);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(ctl[i]);
        sin = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL b2b_err got %b want 000", out_err); end
        checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL b2b_a got %h want 01020304", out_a); end
        checks++; if (out_b !== 32'hA0B0C0D0) begin errors++; $display("FAIL b2b_b got %h want a0b0c0d0", out_b); end
        checks++; if (out_op !== 3'b101) begin errors++; $display("FAIL b2b_op got %b want 101", out_op); end
    endtask

    task automatic test_crc_err();
        send_data(32'h0, 32'h0);
        send_pkt(1'b1, 8'h0A);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL crc_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b010) begin errors++; $display("FAIL crc_err got %b want 010", out_err); end
        checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL crc_a_held got %h want 01020304", out_a); end
        checks++; if (out_b !== 32'hA0B0C0D0) begin errors++; $display("FAIL crc_b_held got %h want a0b0c0d0", out_b); end
        checks++; if (out_op !== 3'b101) begin errors++; $display("FAIL crc_op_held got %b want 101", out_op); end
    endtask

    task automatic test_data_count();
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'h00);
        send_pkt(1'b1, 8'h0B);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL short_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b100) begin errors++; $display("FAIL short_err got %b want 100", out_err); end
        for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'h00);
        send_pkt(1'b1, 8'h0B);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL long_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b100) begin errors++; $display("FAIL long_err got %b want 100", out_err); end
        checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL long_a_held got %h want 01020304", out_a); end
    endtask

    task automatic test_frame_err();
        logic [7:0] ctl;
        send_pkt(1'b0, 8'h00);
        send_pkt(1'b0, 8'h00);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b001) begin errors++; $display("FAIL frame_err got %b want 001", out_err); end
        checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL frame_a_held got %h want 01020304", out_a); end
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_resync_quiet got %b want 0", out_valid); end
        send_bit(1'b1);
        ctl = {1'b0, 3'b011, crc_ref(32'hDEADBEEF, 32'h00FF7F80, 3'b011)};
        send_data(32'hDEADBEEF, 32'h00FF7F80);
        send_pkt(1'b1, ctl);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL recover_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL recover_err got %b want 000", out_err); end
        checks++; if (out_a !== 32'hDEADBEEF) begin errors++; $display("FAIL recover_a got %h want deadbeef", out_a); end
        checks++; if (out_b !== 32'h00FF7F80) begin errors++; $display("FAIL recover_b got %h want 00ff7f80", out_b); end
        checks++; if (out_op !== 3'b011) begin errors++; $display("FAIL recover_op got %b want 011", out_op); end
    endtask

    task automatic test_reset_mid_ctl();
        int v0;
        logic [7:0] ctl;
        ctl = {1'b0, 3'b101, crc_ref(32'h01020304, 32'hA0B0C0D0, 3'b101)};
        send_data(32'h01020304, 32'hA0B0C0D0);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 7; i >= 5; i--) send_bit(ctl[i]);
        v0 = vcnt;
        sin = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL rst_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL rst_b got %h want 0", out_b); end
        checks++; if (out_op !== 3'b000) begin errors++; $display("FAIL rst_op got %b want 000", out_op); end
        rst_n = 1'b1;
        send_bit(1'b1);
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL rst_nopulse got %0d want %0d", vcnt, v0); end
        send_data(32'h01020304, 32'hA0B0C0D0);
        send_pkt(1'b1, ctl);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
        checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL post_rst_err got %b want 000", out_err); end
        checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL post_rst_a got %h want 01020304", out_a); end
        checks++; if (out_b !== 32'hA0B0C0D0) begin errors++; $display("FAIL post_rst_b got %h want a0b0c0d0", out_b); end
        checks++; if (out_op !== 3'b101) begin errors++; $display("FAIL post_rst_op got %b want 101", out_op); end
        send_bit(1'b1);
    endtask

    task automatic test_err_qualify();
        checks++; if (qual_viol !== 0) begin errors++; $display("FAIL err_qualify got %0d want 0", qual_viol); end
    endtask

    initial begin
        rst_n = 1'b0;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_zero_txn();
        test_back_to_back();
        test_crc_err();
        test_data_count();
        test_frame_err();
        test_reset_mid_ctl();
        test_err_qualify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtm_alu_deserializer_p.md
MTM_ALU_DESERIALIZER_P -- requirements
Module: mtm_alu_deserializer_p

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter NBYTES = WIDTH/8, a derived value (not overridable) giving the number of data packets per operand.
REQ-003 SHALL have port clk, input, 1 bit: the clock. All logic is on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, synchronous, active-low.
REQ-005 SHALL have port sin, input, 1 bit: the serial line, idle high, sampled one bit per clk cycle.
REQ-006 SHALL have port out_a, output, WIDTH bits: operand A.
REQ-007 SHALL have port out_b, output, WIDTH bits: operand B.
REQ-008 SHALL have port out_op, output, 3 bits: the operation code.
REQ-009 SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a completed transaction or a detected error.
REQ-010 SHALL have port out_err, output, 3 bits: {err_data, err_crc, err_frame}, qualified by out_valid.

Function
REQ-011 SHALL treat a packet as 11 bits: start=0, type (0=DATA, 1=CTL), 8 payload bits MSB first, stop=1.
REQ-012 SHALL treat a transaction as 2*NBYTES DATA packets (A bytes MSB-first, then B bytes MSB-first) followed by one CTL packet.
REQ-013 SHALL decode the CTL payload as {1'b0, op[2:0], crc[3:0]}.
REQ-014 SHALL use an FSM with states IDLE, TYPE, PAYLOAD, STOP, RESYNC.
REQ-015 SHALL move IDLE->TYPE on sin=0 and stay in IDLE on sin=1.
REQ-016 SHALL latch the type bit on TYPE->PAYLOAD.
REQ-017 SHALL go PAYLOAD->STOP after exactly 8 payload bits, counted by a 3-bit bit counter that wraps 7->0.
REQ-018 SHALL, in STOP with sin=1, accept the packet and go to IDLE.
REQ-019 SHALL, in STOP with sin=0, raise a frame error and go to RESYNC.
REQ-020 SHALL stay in RESYNC until sin=1 is sampled, then go to IDLE.
REQ-021 SHALL, on an accepted DATA packet, shift the payload into a 2*WIDTH shift register and increment a data-packet counter; the counter saturates at 2*NBYTES+1, and surplus bytes are discarded without shifting.
REQ-022 SHALL compute the CRC as x^4+x+1, initial value 0, fed serially MSB first over {A, B, 1'b1, op}, i.e. 2*WIDTH+4 bits; per bit: fb = c[3]^bit, c <= {c[2], c[1], c[0]^fb, fb}.
REQ-023 SHALL evaluate an accepted CTL packet with this error priority: err_data if the data count != 2*NBYTES; otherwise err_crc if the computed CRC != received crc; otherwise success.
REQ-024 SHALL assert out_valid for exactly one cycle, in the cycle after the clock edge that samples the CTL stop bit, with out_err set per REQ-023.
REQ-025 SHALL, on success only, update out_a, out_b and out_op in the same cycle as out_valid; the outputs hold until the next success.
REQ-026 SHALL, on a frame error, pulse out_valid with out_err=3'b001 in the cycle after the failing stop sample; out_a, out_b and out_op are left unchanged.
REQ-027 SHALL clear the data counter, shift register and CRC state after every CTL packet and every frame error; the next transaction begins clean.
REQ-028 SHALL accept back-to-back packets: a start bit sampled in the cycle immediately after a stop bit is accepted (IDLE detects it with no gap).
REQ-029 SHALL hold out_err at 0 whenever out_valid=0.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, set state=IDLE, all counters=0, shift register=0, CRC=0, out_a=0, out_b=0, out_op=0, out_valid=0 and out_err=0.
REQ-031 SHALL, on reset asserted mid-packet, abort the packet with no out_valid pulse; after release, sin high for one cycle followed by a start bit is decoded normally.

Verification
REQ-032 SHALL cover: WIDTH=32, 8 DATA packets of 8'h00, CTL 8'h0B (op=0, crc=4'b1011) -> one out_valid pulse, out_err=000, out_a=0, out_b=0, out_op=0.
REQ-033 SHALL cover: the same stream with CTL 8'h0A -> out_valid pulse, out_err=010, outputs unchanged from the prior values.
REQ-034 SHALL cover: 7 DATA packets then CTL 8'h0B -> out_err=100; then 9 DATA packets then CTL -> out_err=100.
REQ-035 SHALL cover: stop bit of the 3rd DATA packet driven 0, sin held 0 for 5 cycles then 1 -> out_err=001 one cycle after the bad stop; then a full valid transaction -> out_err=000.
REQ-036 SHALL cover: A=32'h01020304, B=32'hA0B0C0D0, op=3'b101 with the reference-model CRC, sent back-to-back -> out_a, out_b and out_op match exactly, with out_valid 1 cycle after the CTL stop.
REQ-037 SHALL cover: rst_n pulsed low during the PAYLOAD of the CTL packet -> no out_valid pulse, all outputs 0; then a full valid transaction succeeds.
